// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one multi-cycle modular add/sub unit between NREQ requesters.
// Latches the winner's operands, handshakes with the adder, returns the result and flags a stuck adder.
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int wI      = 448,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_mode,
    input  logic [NREQ*wI-1:0] req_x,
    input  logic [NREQ*wI-1:0] req_y,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [wI-1:0]      result,
    output logic               err_timeout,
    output logic               add_enable,
    output logic               add_mode,
    output logic [wI-1:0]      add_x,
    output logic [wI-1:0]      add_y,
    input  logic               add_ready,
    input  logic [wI-1:0]      add_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RELEASE
    } state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     ptr_reg, ptr_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [CW-1:0]     wait_reg, wait_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [wI-1:0]     result_reg, result_next;
    logic              err_reg, err_next;
    logic              add_enable_reg, add_enable_next;
    logic              add_mode_reg, add_mode_next;
    logic [wI-1:0]     add_x_reg, add_x_next;
    logic [wI-1:0]     add_y_reg, add_y_next;

    logic [wI-1:0]     x_arr [NREQ];
    logic [wI-1:0]     y_arr [NREQ];
    logic [IW-1:0]     cand_idx [NREQ];
    logic [NREQ-1:0]   cand_req;
    logic              win_found;
    logic [IW-1:0]     win_idx;

    // Candidate gi is the requester gi places after the pointer, so scanning
    // candidates in order gives rotating priority.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [IW:0] sum;
        assign x_arr[gi]    = req_x[gi*wI +: wI];
        assign y_arr[gi]    = req_y[gi*wI +: wI];
        assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi);
        assign cand_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = cand_idx[0];
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && cand_req[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        idx_next        = idx_reg;
        wait_next       = wait_reg;
        gnt_next        = '0;
        done_next       = '0;
        result_next     = result_reg;
        err_next        = err_reg;
        add_enable_next = add_enable_reg;
        add_mode_next   = add_mode_reg;
        add_x_next      = add_x_reg;
        add_y_next      = add_y_reg;

        case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    idx_next          = win_idx;
                    add_mode_next     = req_mode[win_idx];
                    add_x_next        = x_arr[win_idx];
                    add_y_next        = y_arr[win_idx];
                    gnt_next[win_idx] = 1'b1;
                    add_enable_next   = 1'b1;
                    wait_next         = '0;
                    state_next        = S_EXEC;
                end
            end
            S_EXEC: begin
                wait_next = wait_reg + 1'b1;
                // A ready arriving on the last allowed cycle still counts as success.
                if (add_ready) begin
                    result_next        = add_o;
                    done_next[idx_reg] = 1'b1;
                    add_enable_next    = 1'b0;
                    state_next         = S_RELEASE;
                end else if (wait_reg == CW'(TIMEOUT - 1)) begin
                    err_next           = 1'b1;
                    result_next        = '0;
                    done_next[idx_reg] = 1'b1;
                    add_enable_next    = 1'b0;
                    state_next         = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // One idle cycle with enable low lets the adder drop ready.
                ptr_next   = (idx_reg == IW'(NREQ - 1)) ? '0 : idx_reg + 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            ptr_reg        <= '0;
            idx_reg        <= '0;
            wait_reg       <= '0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
            add_enable_reg <= 1'b0;
            add_mode_reg   <= 1'b0;
            add_x_reg      <= '0;
            add_y_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            idx_reg        <= idx_next;
            wait_reg       <= wait_next;
            gnt_reg        <= gnt_next;
            done_reg       <= done_next;
            result_reg     <= result_next;
            err_reg        <= err_next;
            add_enable_reg <= add_enable_next;
            add_mode_reg   <= add_mode_next;
            add_x_reg      <= add_x_next;
            add_y_reg      <= add_y_next;
        end
    end

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign result      = result_reg;
    assign err_timeout = err_reg;
    assign add_enable  = add_enable_reg;
    assign add_mode    = add_mode_reg;
    assign add_x       = add_x_reg;
    assign add_y       = add_y_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural modular adder (optionally stuck), vector table,
// scoreboard of expected done results and hand-written arbitration/timeout/reset sequences.
module tb_adder_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 448;
    localparam int TIMEOUT = 8;
    localparam logic [W-1:0] P = {W{1'b1}} - (W'(1) << 224);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_mode = '0;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic [NREQ-1:0]   gnt, done;
    logic [W-1:0]      result, add_x, add_y;
    logic              err_timeout, add_enable, add_mode;
    logic              add_ready = 1'b0;
    logic [W-1:0]      add_o = '0;

    int acnt = 0;
    bit stuck = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int last_gnt_cyc = 0;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       err;
        int         lat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int         idx;
        logic       mode;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    adder_arbiter #(.NREQ(NREQ), .wI(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
        .req_x(req_x), .req_y(req_y), .gnt(gnt), .done(done), .result(result),
        .err_timeout(err_timeout), .add_enable(add_enable), .add_mode(add_mode),
        .add_x(add_x), .add_y(add_y), .add_ready(add_ready), .add_o(add_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] modop(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        if (!m) begin
            s = {1'b0, x} + {1'b0, y};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
        end else if (x >= y) begin
            s = {1'b0, x - y};
        end else begin
            s = {1'b0, x} + {1'b0, P} - {1'b0, y};
        end
        return s[W-1:0];
    endfunction

    // Adder stand-in: ready after four enabled edges, cleared when enable drops.
    always @(posedge clk) begin
        if (!add_enable) begin
            acnt      <= 0;
            add_ready <= 1'b0;
        end else if (acnt < 3) begin
            acnt <= acnt + 1;
        end else begin
            add_ready <= !stuck;
            add_o     <= modop(add_mode, add_x, add_y);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int idx, input logic mode, input logic [W-1:0] x, input logic [W-1:0] y);
        req_mode[idx]      = mode;
        req_x[idx*W +: W]  = x;
        req_y[idx*W +: W]  = y;
    endtask

    task automatic push(input int idx, input logic [W-1:0] res, input logic err, input int lat);
        sb_t e;
        e.idx = idx; e.res = res; e.err = err; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(output int who);
        who = -1;
        for (int i = 0; i < 40 && who < 0; i++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (gnt[k]) who = k;
        end
        if (who < 0) begin
            n_cmp++; n_err++;
            $display("FAIL gnt_wait: got no gnt want gnt within 40 cycles");
        end
    endtask

    task automatic wait_done(output int who);
        who = -1;
        for (int i = 0; i < 40 && who < 0; i++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (done[k]) who = k;
        end
        if (who < 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_wait: got no done want done within 40 cycles");
        end
    endtask

    // Monitor: one-hot checks and scoreboard comparison on every done pulse.
    initial begin
        sb_t e;
        int  di;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (gnt != '0 || done != '0)
                    chk("onehot", {$onehot0(gnt), $onehot0(done), ((gnt & done) == '0)}, 3'b111);
                if (gnt != '0) last_gnt_cyc = cyc;
                if (done != '0) begin
                    di = -1;
                    for (int k = 0; k < NREQ; k++) if (done[k]) di = k;
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_done: got done[%0d] want none", di);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_idx", di, e.idx);
                        chk("done_result", result, e.res);
                        chk("done_err", err_timeout, e.err);
                        chk("done_latency", cyc - last_gnt_cyc, e.lat);
                        $display("done[%0d] result=%0h err=%0b", di, result, err_timeout);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000ns");
        $fatal(1);
    end

    initial begin
        int who;
        int prev;
        bit any_done;

        vecs[0] = '{0, 1'b0, W'(5), W'(7), W'(12)};
        vecs[1] = '{2, 1'b1, W'(7), W'(5), W'(2)};
        vecs[2] = '{1, 1'b0, P - 1, W'(1), W'(0)};
        vecs[3] = '{3, 1'b1, W'(5), W'(7), P - 2};
        vecs[4] = '{1, 1'b0, P - 1, P - 1, P - 2};
        vecs[5] = '{0, 1'b1, W'(0), P - 1, W'(1)};

        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_en", add_enable, 0);
        chk("rst_mode", add_mode, 0);
        chk("rst_x", add_x, 0);
        chk("rst_y", add_y, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            drive(vecs[v].idx, vecs[v].mode, vecs[v].x, vecs[v].y);
            push(vecs[v].idx, vecs[v].exp, 1'b0, 5);
            req[vecs[v].idx] = 1'b1;
            wait_gnt(who);
            chk("vec_gnt_idx", who, vecs[v].idx);
            chk("vec_add_x", add_x, vecs[v].x);
            chk("vec_add_y", add_y, vecs[v].y);
            chk("vec_add_mode", add_mode, vecs[v].mode);
            chk("vec_add_en", add_enable, 1);
            req[vecs[v].idx] = 1'b0;
            wait_done(who);
            chk("vec_en_done", add_enable, 0);
            @(negedge clk);
            chk("vec_en_release", add_enable, 0);
            repeat (2) @(negedge clk);
            chk("vec_result_held", result, vecs[v].exp);
            $display("vec %0d: req[%0d] mode=%0b result=%0h", v, vecs[v].idx, vecs[v].mode, result);
        end

        // Two requesters raised together after reset, then held.
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        drive(0, 1'b0, W'(1), W'(2));
        drive(1, 1'b1, W'(10), W'(3));
        for (int n = 0; n < 4; n++) push(n % 2, (n % 2 == 0) ? W'(3) : W'(7), 1'b0, 5);
        req = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(who);
            chk("pair_order", who, n % 2);
            $display("pair gnt %0d -> req[%0d] at cycle %0d", n, who, cyc);
        end
        req = '0;
        wait_done(who);

        // All four held: strict rotation, 7 cycles per operation.
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        for (int i = 0; i < NREQ; i++) drive(i, 1'b0, W'(i + 1), W'(100));
        for (int n = 0; n < 8; n++) push(n % 4, W'(n % 4 + 101), 1'b0, 5);
        req = 4'b1111;
        prev = 0;
        for (int n = 0; n < 8; n++) begin
            wait_gnt(who);
            chk("rr_order", who, n % 4);
            if (n > 0) chk("rr_spacing", cyc - prev, 7);
            $display("rr gnt %0d -> req[%0d] at cycle %0d", n, who, cyc);
            prev = cyc;
        end
        req = '0;
        wait_done(who);

        // Reset in the middle of EXEC: no done, pointer back to 0.
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        drive(2, 1'b0, W'(4), W'(4));
        push(2, W'(8), 1'b0, 5);
        req[2] = 1'b1;
        wait_gnt(who);
        req[2] = 1'b0;
        wait_done(who);
        drive(3, 1'b0, W'(9), W'(9));
        req[3] = 1'b1;
        wait_gnt(who);
        chk("abort_gnt_idx", who, 3);
        req[3] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_en_low", add_enable, 0);
        chk("abort_no_done_rst", done, 0);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            any_done = any_done | (|done);
        end
        chk("abort_no_done", any_done, 0);
        drive(1, 1'b1, W'(20), W'(6));
        push(1, W'(14), 1'b0, 5);
        req = 4'b1010;
        wait_gnt(who);
        chk("abort_ptr_reset", who, 1);
        $display("after abort gnt -> req[%0d]", who);
        req = '0;
        wait_done(who);

        // Stuck adder: timeout, sticky error, service continues.
        stuck = 1'b1;
        drive(2, 1'b0, W'(5), W'(7));
        push(2, W'(0), 1'b1, TIMEOUT);
        req[2] = 1'b1;
        wait_gnt(who);
        req[2] = 1'b0;
        wait_done(who);
        chk("to_err_set", err_timeout, 1);
        stuck = 1'b0;
        drive(0, 1'b0, W'(3), W'(4));
        push(0, W'(7), 1'b1, 5);
        req[0] = 1'b1;
        wait_gnt(who);
        chk("to_next_gnt", who, 0);
        req[0] = 1'b0;
        wait_done(who);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", err_timeout, 1);
        reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0;
        chk("to_err_cleared", err_timeout, 0);

        repeat (5) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
